// File: rtl/spiker_adapter_pkg.sv
// Shared types and widths for the spike collector and spiker_writer.
// Both blocks import this so the packed data width cannot drift.
package spiker_adapter_pkg;

   localparam int N_OUT      = 96;
   localparam int CNT_W      = 8;
   localparam int DATA_WIDTH = N_OUT * CNT_W;
   localparam int STEP_W     = 16;
   localparam int IDX_W      = $clog2(N_OUT);

   localparam int WR_WIDTH = 32;
   localparam int WR_N_REG = DATA_WIDTH / WR_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } collector_state_e;

endpackage

// File: rtl/spiker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The clear input has priority over the increment input.
module spiker_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W:0]   w_sum;

   // The carry out of the widened sum marks the saturation point
   assign w_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sum[CNT_W]) begin
         r_cnt <= w_sum[CNT_W-1:0];
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/spiker_spike_collector.sv
// Counts output-neuron spikes over a window of timesteps.
// At the end of the window it pulses sample_o with the packed counts on data_o.
module spiker_spike_collector
   import spiker_adapter_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [STEP_W-1:0]     n_steps_i,
   input  logic                  spike_valid_i,
   input  logic [IDX_W-1:0]      spike_idx_i,
   output logic                  spike_ready_o,
   input  logic                  step_done_i,
   output logic                  busy_o,
   output logic                  sample_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  idx_err_o
);

   if (DATA_WIDTH != WR_N_REG * WR_WIDTH) begin : g_width_chk
      $error("collector DATA_WIDTH does not match writer width");
   end

   collector_state_e  r_state;
   collector_state_e  w_next;
   logic [STEP_W-1:0] r_steps_q;
   logic [STEP_W-1:0] r_step_cnt;
   logic              r_idx_err;
   logic              w_collect;
   logic              w_accept;
   logic              w_in_range;
   logic              w_inc_en;
   logic              w_last;

   assign w_collect  = (r_state == COLLECT);
   assign w_in_range = ({1'b0, spike_idx_i} < (IDX_W + 1)'(N_OUT));
   assign w_accept   = spike_valid_i && spike_ready_o;
   assign w_inc_en   = w_accept && w_in_range;
   assign w_last     = w_collect && step_done_i &&
                       (r_step_cnt == r_steps_q - STEP_W'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      spike_ready_o = 1'b0;
      busy_o        = 1'b0;
      sample_o      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_next = IDLE;
         end
         COLLECT: begin
            busy_o        = 1'b1;
            spike_ready_o = !start_i;
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            sample_o = !start_i;
            w_next   = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      if (start_i) begin
         w_next = COLLECT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_steps_q  <= '0;
         r_step_cnt <= '0;
         r_idx_err  <= 1'b0;
      end else if (start_i) begin
         r_steps_q  <= (n_steps_i == '0) ? STEP_W'(1) : n_steps_i;
         r_step_cnt <= '0;
         r_idx_err  <= 1'b0;
      end else begin
         if (w_collect && step_done_i) begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
         end
         if (w_accept && !w_in_range) begin
            r_idx_err <= 1'b1;
         end
      end
   end

   assign idx_err_o = r_idx_err;

   for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
      logic w_inc;
      assign w_inc = w_inc_en && (spike_idx_i == IDX_W'(k));
      spiker_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .i_clr  (start_i),
         .i_inc  (w_inc),
         .o_cnt  (data_o[k*CNT_W +: CNT_W])
      );
   end

endmodule
